flash_read: RTL and testbench



---
 rtl/flash_read_pkg.sv | 40 ++++
 rtl/flash_read_if.sv | 11 +
 rtl/flash_gap_timer.sv | 36 +++
 rtl/flash_read.sv | 215 +++++++++++++++++++++
 tb/tb_flash_read.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_read_pkg.sv
// Shared constants, state encodings and helpers for the SPI NOR read controller.
package flash_read_pkg;

    localparam logic [7:0] CMD_RDSR  = 8'h05;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] DUMMY     = 8'h00;

    localparam int unsigned DELAY_5MS    = 250_000;
    localparam int unsigned POLL_MAX_DEF = 16;

    localparam logic [1:0] FAIL_NONE = 2'b00;
    localparam logic [1:0] FAIL_BUSY = 2'b01;
    localparam logic [1:0] FAIL_LEN  = 2'b10;

    typedef enum logic [4:0] {
        M_IDLE = 5'b00001,
        M_RDSR = 5'b00010,
        M_GAP  = 5'b00100,
        M_READ = 5'b01000,
        M_END  = 5'b10000
    } main_state_t;

    typedef enum logic [1:0] {
        S_CMD  = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } read_phase_t;

    // Address bytes go out most significant first.
    function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = addr[23:16];
            2'd1:    b = addr[15:8];
            default: b = addr[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/flash_read_if.sv
// Byte-level SPI master port shared with flash_write; the controller is the master side.
interface flash_read_if;
    logic       req;
    logic [7:0] din;
    logic       finish;
    logic       done;
    logic [7:0] dout;

    modport master (output req, output din, output finish, input done, input dout);
    modport slave  (input req, input din, input finish, output done, output dout);
endinterface

// File: rtl/flash_gap_timer.sv
// Inter-transaction gap timer: a start pulse arms it, expire_o pulses DELAY_CYC cycles later.
module flash_gap_timer
    import flash_read_pkg::*;
#(
    parameter int unsigned DELAY_CYC = DELAY_5MS
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic expire_o
);

    localparam int CW = (DELAY_CYC > 2) ? $clog2(DELAY_CYC) : 1;

    logic [CW-1:0] cnt_q;
    logic          run_q;

    assign expire_o = run_q && (cnt_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            cnt_q <= CW'(DELAY_CYC - 1);
            run_q <= 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/flash_read.sv
// SPI NOR read controller: polls RDSR until not busy, then issues READ and streams bytes out.
module flash_read
    import flash_read_pkg::*;
#(
    parameter int unsigned DELAY_CYC = DELAY_5MS,
    parameter int unsigned POLL_MAX  = POLL_MAX_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rden,
    input  logic [23:0]  rdaddress,
    input  logic [10:0]  rdlen,
    output logic         rdbusy,
    output logic [7:0]   rd_data,
    output logic         rd_vld,
    output logic         rddone,
    output logic [1:0]   fail,
    flash_read_if.master spi
);

    localparam int PW = (POLL_MAX > 2) ? $clog2(POLL_MAX) : 1;

    main_state_t state_q;
    read_phase_t phase_q;
    logic [10:0] cnt_q;
    logic [PW-1:0] poll_q;
    logic        wip_q;
    logic        pend_q;
    logic        out_q;
    logic        tstart_q;
    logic [23:0] addr_q;
    logic [10:0] len_q;

    logic        req_q;
    logic [7:0]  din_q;
    logic        finish_q;
    logic        rd_vld_q;
    logic [7:0]  rd_data_q;
    logic        rddone_q;
    logic [1:0]  fail_q;
    logic        rdbusy_q;

    logic        done_ok;
    logic        gap_exp;

    // A done only counts while a request is outstanding.
    assign done_ok = spi.done && out_q;

    assign spi.req    = req_q;
    assign spi.din    = din_q;
    assign spi.finish = finish_q;
    assign rd_vld     = rd_vld_q;
    assign rd_data    = rd_data_q;
    assign rddone     = rddone_q;
    assign fail       = fail_q;
    assign rdbusy     = rdbusy_q;

    flash_gap_timer #(.DELAY_CYC(DELAY_CYC)) u_gap (
        .clk      (clk),
        .rst      (rst),
        .start_i  (tstart_q),
        .expire_o (gap_exp)
    );

    // Request parameters are plain data, captured on an accepted request.
    always_ff @(posedge clk) begin
        if (state_q == M_IDLE && rden) begin
            addr_q <= rdaddress;
            len_q  <= rdlen;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= M_IDLE;
            phase_q   <= S_CMD;
            cnt_q     <= '0;
            poll_q    <= '0;
            wip_q     <= 1'b0;
            pend_q    <= 1'b0;
            out_q     <= 1'b0;
            tstart_q  <= 1'b0;
            req_q     <= 1'b0;
            din_q     <= 8'h00;
            finish_q  <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= 8'h00;
            rddone_q  <= 1'b0;
            fail_q    <= FAIL_NONE;
            rdbusy_q  <= 1'b0;
        end else begin
            req_q    <= 1'b0;
            finish_q <= 1'b0;
            rd_vld_q <= 1'b0;
            rddone_q <= 1'b0;
            fail_q   <= FAIL_NONE;
            tstart_q <= 1'b0;
            pend_q   <= 1'b0;

            // pend_q delays the first request of a transaction by one cycle after din is set.
            if (pend_q) begin
                req_q <= 1'b1;
                out_q <= 1'b1;
            end
            if (done_ok) begin
                out_q <= 1'b0;
            end

            case (state_q)
                M_IDLE: begin
                    if (rden) begin
                        if (rdlen == 11'd0) begin
                            fail_q <= FAIL_LEN;
                        end else begin
                            state_q  <= M_RDSR;
                            rdbusy_q <= 1'b1;
                            din_q    <= CMD_RDSR;
                            pend_q   <= 1'b1;
                            poll_q   <= '0;
                            cnt_q    <= '0;
                        end
                    end
                end

                M_RDSR: begin
                    if (done_ok) begin
                        if (cnt_q == 11'd0) begin
                            cnt_q <= 11'd1;
                            din_q <= DUMMY;
                            req_q <= 1'b1;
                            out_q <= 1'b1;
                        end else begin
                            wip_q    <= spi.dout[0];
                            finish_q <= 1'b1;
                            tstart_q <= 1'b1;
                            cnt_q    <= '0;
                            state_q  <= M_GAP;
                        end
                    end
                end

                M_GAP: begin
                    if (gap_exp) begin
                        if (!wip_q) begin
                            state_q <= M_READ;
                            phase_q <= S_CMD;
                            din_q   <= CMD_READ;
                            pend_q  <= 1'b1;
                        end else if (poll_q < PW'(POLL_MAX - 1)) begin
                            poll_q  <= poll_q + 1'b1;
                            state_q <= M_RDSR;
                            din_q   <= CMD_RDSR;
                            pend_q  <= 1'b1;
                        end else begin
                            fail_q   <= FAIL_BUSY;
                            rdbusy_q <= 1'b0;
                            state_q  <= M_IDLE;
                        end
                    end
                end

                M_READ: begin
                    if (done_ok) begin
                        case (phase_q)
                            S_CMD: begin
                                phase_q <= S_ADDR;
                                cnt_q   <= '0;
                                din_q   <= addr_byte(addr_q, 2'd0);
                                req_q   <= 1'b1;
                                out_q   <= 1'b1;
                            end
                            S_ADDR: begin
                                if (cnt_q == 11'd2) begin
                                    phase_q <= S_DATA;
                                    cnt_q   <= '0;
                                    din_q   <= DUMMY;
                                end else begin
                                    cnt_q <= cnt_q + 11'd1;
                                    din_q <= addr_byte(addr_q, cnt_q[1:0] + 2'd1);
                                end
                                req_q <= 1'b1;
                                out_q <= 1'b1;
                            end
                            S_DATA: begin
                                rd_vld_q  <= 1'b1;
                                rd_data_q <= spi.dout;
                                if (cnt_q == len_q - 11'd1) begin
                                    finish_q <= 1'b1;
                                    tstart_q <= 1'b1;
                                    state_q  <= M_END;
                                end else begin
                                    cnt_q <= cnt_q + 11'd1;
                                    req_q <= 1'b1;
                                    out_q <= 1'b1;
                                end
                            end
                            default: phase_q <= S_CMD;
                        endcase
                    end
                end

                M_END: begin
                    if (gap_exp) begin
                        rddone_q <= 1'b1;
                        rdbusy_q <= 1'b0;
                        state_q  <= M_IDLE;
                    end
                end

                default: state_q <= M_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_read.sv
// Directed bench for flash_read with a byte-level SPI master model answering 4 cycles after req.
module tb_flash_read;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rden = 1'b0;
    logic [23:0] rdaddress = 24'h0;
    logic [10:0] rdlen = 11'd0;
    logic        rdbusy;
    logic [7:0]  rd_data;
    logic        rd_vld;
    logic        rddone;
    logic [1:0]  fail;

    flash_read_if spi ();

    flash_read #(.DELAY_CYC(8), .POLL_MAX(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .rden      (rden),
        .rdaddress (rdaddress),
        .rdlen     (rdlen),
        .rdbusy    (rdbusy),
        .rd_data   (rd_data),
        .rd_vld    (rd_vld),
        .rddone    (rddone),
        .fail      (fail),
        .spi       (spi)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int busy_polls = 0;
    int txn_idx = 0;
    int poll_idx = 0;
    int cd_m = 0;
    logic pend_m = 1'b0;
    logic prev_done = 1'b0;
    logic [7:0] cur_op = 8'h00;
    logic [7:0] bus_log[$];
    logic [7:0] op_log[$];
    logic [7:0] rd_log[$];
    int rddone_cnt = 0;
    int fail01_cnt = 0;
    int fail10_cnt = 0;
    int finish_cnt = 0;
    int vld_err = 0;

    function automatic logic [7:0] exp_data(input int k);
        return 8'(8'hAA + 8'h11 * k);
    endfunction

    function automatic logic [7:0] resp(input logic [7:0] op, input int idx, input int pidx);
        if (op == 8'h05 && idx == 1) return (pidx < busy_polls) ? 8'h01 : 8'h00;
        if (op == 8'h03 && idx >= 4) return exp_data(idx - 4);
        return 8'hFF;
    endfunction

    // SPI master model plus bus / user-side monitors
    always @(posedge clk) begin
        if (rst) begin
            pend_m    <= 1'b0;
            cd_m      <= 0;
            spi.done  <= 1'b0;
            spi.dout  <= 8'h00;
            txn_idx   <= 0;
            poll_idx  <= 0;
            prev_done <= 1'b0;
        end else begin
            prev_done <= spi.done;
            spi.done  <= 1'b0;
            if (rden && !rdbusy) begin
                poll_idx <= 0;
                txn_idx  <= 0;
            end
            if (spi.req) begin
                bus_log.push_back(spi.din);
                if (txn_idx == 0) begin
                    op_log.push_back(spi.din);
                    cur_op <= spi.din;
                end
                spi.dout <= resp((txn_idx == 0) ? spi.din : cur_op, txn_idx, poll_idx);
                txn_idx  <= txn_idx + 1;
                pend_m   <= 1'b1;
                cd_m     <= 2;
            end else if (pend_m) begin
                if (cd_m == 0) begin
                    spi.done <= 1'b1;
                    pend_m   <= 1'b0;
                end else begin
                    cd_m <= cd_m - 1;
                end
            end
            if (spi.finish) begin
                txn_idx    <= 0;
                finish_cnt <= finish_cnt + 1;
                if (cur_op == 8'h05) poll_idx <= poll_idx + 1;
            end
            if (rd_vld) begin
                rd_log.push_back(rd_data);
                if (!prev_done) vld_err <= vld_err + 1;
            end
            if (rddone) rddone_cnt <= rddone_cnt + 1;
            if (fail == 2'b01) fail01_cnt <= fail01_cnt + 1;
            if (fail == 2'b10) fail10_cnt <= fail10_cnt + 1;
        end
    end

    task automatic issue(input logic [23:0] a, input logic [10:0] l);
        rdaddress = a;
        rdlen     = l;
        rden      = 1'b1;
        @(negedge clk);
        rden      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (rdbusy !== 1'b0) begin bad++; $display("FAIL reset_rdbusy got=%b want=0", rdbusy); end
        total++; if (spi.req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", spi.req); end
        total++; if (spi.finish !== 1'b0) begin bad++; $display("FAIL reset_finish got=%b want=0", spi.finish); end
        total++; if (rd_vld !== 1'b0 || rddone !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%b%b want=00", rd_vld, rddone); end
        total++; if (fail !== 2'b00) begin bad++; $display("FAIL reset_fail got=%b want=00", fail); end
        total++; if (spi.din !== 8'h00 || rd_data !== 8'h00) begin bad++; $display("FAIL reset_data din=%h rd_data=%h want=00", spi.din, rd_data); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ready_read();
        logic [7:0] exp_bus[10] = '{8'h05, 8'h00, 8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h00, 8'h00};
        logic [7:0] exp_rd[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        int b_bus = bus_log.size();
        int b_rd = rd_log.size();
        int b_done = rddone_cnt;
        int b_fin = finish_cnt;
        int b_vld = vld_err;
        int lim;
        busy_polls = 0;
        issue(24'h012345, 11'd4);
        total++; if (rdbusy !== 1'b1 || spi.din !== 8'h05) begin bad++; $display("FAIL accept_t1 rdbusy=%b din=%h want 1/05", rdbusy, spi.din); end
        total++; if (spi.req !== 1'b0) begin bad++; $display("FAIL req_t1 got=%b want=0", spi.req); end
        @(negedge clk);
        total++; if (spi.req !== 1'b1) begin bad++; $display("FAIL req_t2 got=%b want=1", spi.req); end
        for (lim = 0; lim < 1000 && rddone_cnt == b_done; lim++) @(negedge clk);
        total++; if (rddone_cnt != b_done + 1) begin bad++; $display("FAIL ready_rddone got=%0d want=1", rddone_cnt - b_done); end
        total++; if (rdbusy !== 1'b0) begin bad++; $display("FAIL ready_rdbusy_end got=%b want=0", rdbusy); end
        total++; if (bus_log.size() - b_bus != 10) begin bad++; $display("FAIL ready_bus_len got=%0d want=10", bus_log.size() - b_bus); end
        else begin
            for (int i = 0; i < 10; i++) begin
                total++;
                if (bus_log[b_bus + i] !== exp_bus[i]) begin bad++; $display("FAIL ready_bus[%0d] got=%h want=%h", i, bus_log[b_bus + i], exp_bus[i]); end
            end
        end
        total++; if (rd_log.size() - b_rd != 4) begin bad++; $display("FAIL ready_vld_cnt got=%0d want=4", rd_log.size() - b_rd); end
        else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (rd_log[b_rd + i] !== exp_rd[i]) begin bad++; $display("FAIL ready_data[%0d] got=%h want=%h", i, rd_log[b_rd + i], exp_rd[i]); end
            end
        end
        total++; if (finish_cnt - b_fin != 2) begin bad++; $display("FAIL ready_finish_cnt got=%0d want=2", finish_cnt - b_fin); end
        total++; if (vld_err != b_vld) begin bad++; $display("FAIL ready_vld_timing got=%0d late strobes want=0", vld_err - b_vld); end
    endtask

    task automatic test_busy_poll();
        logic [7:0] exp_op[4] = '{8'h05, 8'h05, 8'h05, 8'h03};
        int b_op = op_log.size();
        int b_rd = rd_log.size();
        int b_done = rddone_cnt;
        int lim;
        busy_polls = 2;
        issue(24'h000010, 11'd2);
        for (lim = 0; lim < 1000 && rddone_cnt == b_done; lim++) @(negedge clk);
        total++; if (rddone_cnt != b_done + 1) begin bad++; $display("FAIL poll_rddone got=%0d want=1", rddone_cnt - b_done); end
        total++; if (op_log.size() - b_op != 4) begin bad++; $display("FAIL poll_txn_cnt got=%0d want=4", op_log.size() - b_op); end
        else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (op_log[b_op + i] !== exp_op[i]) begin bad++; $display("FAIL poll_op[%0d] got=%h want=%h", i, op_log[b_op + i], exp_op[i]); end
            end
        end
        total++; if (rd_log.size() - b_rd != 2 || rd_log[rd_log.size() - 1] !== 8'hBB) begin bad++; $display("FAIL poll_data cnt=%0d last=%h want 2/BB", rd_log.size() - b_rd, rd_log[rd_log.size() - 1]); end
    endtask

    task automatic test_busy_timeout();
        int b_op = op_log.size();
        int b_f1 = fail01_cnt;
        int b_done = rddone_cnt;
        int n_read = 0;
        int n_rdsr = 0;
        int lim;
        busy_polls = 1000;
        issue(24'h00ABCD, 11'd4);
        for (lim = 0; lim < 2000 && fail01_cnt == b_f1; lim++) begin
            @(negedge clk);
            if (fail == 2'b01) begin
                total++;
                if (rdbusy !== 1'b0) begin bad++; $display("FAIL timeout_rdbusy got=%b want=0", rdbusy); end
            end
        end
        total++; if (fail01_cnt != b_f1 + 1) begin bad++; $display("FAIL timeout_fail01 got=%0d want=1", fail01_cnt - b_f1); end
        for (int i = b_op; i < op_log.size(); i++) begin
            if (op_log[i] == 8'h05) n_rdsr++;
            if (op_log[i] == 8'h03) n_read++;
        end
        total++; if (n_rdsr != 16) begin bad++; $display("FAIL timeout_rdsr_cnt got=%0d want=16", n_rdsr); end
        total++; if (n_read != 0) begin bad++; $display("FAIL timeout_read_ops got=%0d want=0", n_read); end
        total++; if (rddone_cnt != b_done) begin bad++; $display("FAIL timeout_rddone got=%0d want=0", rddone_cnt - b_done); end
        busy_polls = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_zero_len();
        int b_bus = bus_log.size();
        int b_f2 = fail10_cnt;
        issue(24'h123456, 11'd0);
        total++; if (fail !== 2'b10) begin bad++; $display("FAIL zlen_fail got=%b want=10", fail); end
        total++; if (rdbusy !== 1'b0) begin bad++; $display("FAIL zlen_rdbusy got=%b want=0", rdbusy); end
        @(negedge clk);
        total++; if (fail !== 2'b00) begin bad++; $display("FAIL zlen_fail_pulse got=%b want=00", fail); end
        repeat (20) @(negedge clk);
        total++; if (bus_log.size() != b_bus) begin bad++; $display("FAIL zlen_no_req got=%0d bytes want=0", bus_log.size() - b_bus); end
        total++; if (fail10_cnt != b_f2 + 1) begin bad++; $display("FAIL zlen_pulse_cnt got=%0d want=1", fail10_cnt - b_f2); end
    endtask

    task automatic test_rden_ignored();
        logic [7:0] exp_bus[9] = '{8'h05, 8'h00, 8'h03, 8'hAB, 8'hCD, 8'hEF, 8'h00, 8'h00, 8'h00};
        int b_bus = bus_log.size();
        int b_rd = rd_log.size();
        int b_done = rddone_cnt;
        int lim;
        issue(24'hABCDEF, 11'd3);
        repeat (6) @(negedge clk);
        issue(24'h111111, 11'd5);
        for (lim = 0; lim < 1000 && rddone_cnt == b_done; lim++) @(negedge clk);
        repeat (40) @(negedge clk);
        total++; if (rddone_cnt != b_done + 1) begin bad++; $display("FAIL ign_rddone got=%0d want=1", rddone_cnt - b_done); end
        total++; if (rd_log.size() - b_rd != 3) begin bad++; $display("FAIL ign_vld_cnt got=%0d want=3", rd_log.size() - b_rd); end
        total++; if (bus_log.size() - b_bus != 9) begin bad++; $display("FAIL ign_bus_len got=%0d want=9", bus_log.size() - b_bus); end
        else begin
            for (int i = 0; i < 9; i++) begin
                total++;
                if (bus_log[b_bus + i] !== exp_bus[i]) begin bad++; $display("FAIL ign_bus[%0d] got=%h want=%h", i, bus_log[b_bus + i], exp_bus[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int b_rd = rd_log.size();
        int lim;
        issue(24'h000100, 11'd8);
        for (lim = 0; lim < 1000 && rd_log.size() - b_rd < 2; lim++) @(negedge clk);
        total++; if (rd_log.size() - b_rd < 2) begin bad++; $display("FAIL mid_reached_data got=%0d want>=2", rd_log.size() - b_rd); end
        rst = 1'b1;
        #1;
        total++; if (rdbusy !== 1'b0 || spi.req !== 1'b0 || spi.finish !== 1'b0) begin bad++; $display("FAIL mid_rst_ctrl rdbusy=%b req=%b finish=%b want 000", rdbusy, spi.req, spi.finish); end
        total++; if (rd_vld !== 1'b0 || rddone !== 1'b0 || fail !== 2'b00) begin bad++; $display("FAIL mid_rst_strobes vld=%b done=%b fail=%b want 0/0/00", rd_vld, rddone, fail); end
        total++; if (spi.din !== 8'h00 || rd_data !== 8'h00) begin bad++; $display("FAIL mid_rst_data din=%h rd_data=%h want 00", spi.din, rd_data); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_long();
        int b_rd = rd_log.size();
        int b_done = rddone_cnt;
        int nbad = 0;
        int lim;
        issue(24'h000000, 11'd2047);
        for (lim = 0; lim < 20000 && rddone_cnt == b_done; lim++) @(negedge clk);
        total++; if (rddone_cnt != b_done + 1) begin bad++; $display("FAIL long_rddone got=%0d want=1", rddone_cnt - b_done); end
        total++; if (rd_log.size() - b_rd != 2047) begin bad++; $display("FAIL long_vld_cnt got=%0d want=2047", rd_log.size() - b_rd); end
        else begin
            for (int i = 0; i < 2047; i++) if (rd_log[b_rd + i] !== exp_data(i)) nbad++;
            total++; if (nbad != 0) begin bad++; $display("FAIL long_data got=%0d wrong bytes want=0", nbad); end
            total++; if (rd_log[b_rd + 2046] !== 8'h88) begin bad++; $display("FAIL long_last got=%h want=88", rd_log[b_rd + 2046]); end
        end
    endtask

    initial begin
        test_reset();
        test_ready_read();
        test_busy_poll();
        test_busy_timeout();
        test_zero_len();
        test_rden_ignored();
        test_reset_mid();
        test_long();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
